input_event_buffer: RTL

- Parametrised successor to the single-register key latch.
- Accepts CPU bus writes of user-input codes into NUM_CH independent channels. Each channel has a DEPTH-entry FIFO.
- Presents each channel's head value on key_out. Heads are retired on the slow 10 Hz tick after a programmable number of ticks.
- Adds per-channel flush, sticky overflow flags and a read-back status path. Sits between the bus slave interface and the game/display logic.

---
 rtl/input_event_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/input_event_buffer.sv
// Multi-channel input-code buffer: bus writes push codes into per-channel FIFOs; heads retire on slow ticks.
// Latency: push visible on key_out one edge after the write; readdata valid one edge after read.
// Backpressure: none; a push to a full channel without a same-cycle pop is dropped and sets a sticky overflow flag.
module input_event_buffer #(
   parameter int DATA_W     = 8,
   parameter int NUM_CH     = 4,
   parameter int DEPTH      = 4,
   parameter int HOLD_TICKS = 1,
   parameter int ADDR_W     = 3
) (
   input  logic                     CLOCK50M,
   input  logic                     RESET_N,
   input  logic                     clock10h,
   input  logic                     write,
   input  logic                     read,
   input  logic [ADDR_W-1:0]        address,
   input  logic [DATA_W-1:0]        user_input,
   output logic [DATA_W-1:0]        readdata,
   output logic [NUM_CH*DATA_W-1:0] key_out,
   output logic [NUM_CH-1:0]        key_valid
);

   localparam int                PTR_W     = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] A_FLUSH   = ADDR_W'(NUM_CH);
   localparam logic [ADDR_W-1:0] A_OVF     = ADDR_W'(NUM_CH + 1);
   localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);
   localparam logic [7:0]        HOLD_LAST = 8'(HOLD_TICKS - 1);

   logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
   logic [PTR_W-1:0]  wr_ptr [NUM_CH];
   logic [PTR_W-1:0]  rd_ptr [NUM_CH];
   logic [PTR_W:0]    cnt [NUM_CH];
   logic [7:0]        hold_cnt [NUM_CH];
   logic [DATA_W-1:0] head [NUM_CH];

   logic [NUM_CH-1:0] ovf;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] push_req;
   logic [NUM_CH-1:0] push_ok;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] flush;
   logic [NUM_CH-1:0] ovf_set;
   logic [NUM_CH-1:0] ovf_clr;

   logic              clock10h_q;
   logic              tick_rise;
   logic [DATA_W-1:0] rd_next;
   logic [DATA_W-1:0] status;

   // One pop opportunity per rising edge of the slow tick, however long it stays high.
   assign tick_rise = clock10h & ~clock10h_q;

   // Per-channel decode: flush beats tick, a pop frees the slot for a same-cycle push into a full channel.
   always_comb begin
      empty    = '0;
      full     = '0;
      push_req = '0;
      push_ok  = '0;
      pop      = '0;
      flush    = '0;
      ovf_set  = '0;
      ovf_clr  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         head[i]     = '0;
         empty[i]    = (cnt[i] == '0);
         full[i]     = (cnt[i] == FULL_CNT);
         if (!empty[i]) head[i] = mem[i][rd_ptr[i]];
         push_req[i] = write && (address == ADDR_W'(i));
         flush[i]    = write && (address == A_FLUSH) && user_input[i];
         ovf_clr[i]  = write && (address == A_OVF) && user_input[i];
         pop[i]      = tick_rise && !empty[i] && (hold_cnt[i] == HOLD_LAST) && !flush[i];
         push_ok[i]  = push_req[i] && (!full[i] || pop[i]);
         ovf_set[i]  = push_req[i] && full[i] && !pop[i];
      end
   end

   // Read mux: channel heads, then packed full/empty status, then overflow flags.
   always_comb begin
      rd_next = '0;
      status  = '0;
      status[NUM_CH-1:0]          = empty;
      status[2*NUM_CH-1 -: NUM_CH] = full;
      for (int i = 0; i < NUM_CH; i++) begin
         if (address == ADDR_W'(i)) rd_next = head[i];
      end
      if (address == A_FLUSH) rd_next = status;
      if (address == A_OVF)   rd_next[NUM_CH-1:0] = ovf;
   end

   // Output packing comes from registered state only.
   always_comb begin
      key_out   = '0;
      key_valid = ~empty;
      for (int i = 0; i < NUM_CH; i++) begin
         key_out[i*DATA_W +: DATA_W] = head[i];
      end
   end

   // FIFO storage; no reset needed since heads are masked by the count.
   always_ff @(posedge CLOCK50M) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push_ok[i]) mem[i][wr_ptr[i]] <= user_input;
      end
   end

   // Pointers, counts, hold counters, overflow flags, tick history and read data.
   always_ff @(posedge CLOCK50M or negedge RESET_N) begin
      if (!RESET_N) begin
         clock10h_q <= 1'b0;
         readdata   <= '0;
         ovf        <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
            cnt[i]      <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         clock10h_q <= clock10h;
         if (read) readdata <= rd_next;
         for (int i = 0; i < NUM_CH; i++) begin
            ovf[i] <= (ovf[i] & ~ovf_clr[i]) | ovf_set[i];
            if (flush[i]) begin
               wr_ptr[i]   <= '0;
               rd_ptr[i]   <= '0;
               cnt[i]      <= '0;
               hold_cnt[i] <= '0;
            end else begin
               if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
               if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
               if (push_ok[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
               else if (!push_ok[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
               if (tick_rise && !empty[i]) begin
                  hold_cnt[i] <= pop[i] ? 8'd0 : hold_cnt[i] + 8'd1;
               end
            end
         end
      end
   end

endmodule
